// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates exceptions, machine interrupts and MRET in XB,
// then issues the CSR commit pulse, the fetch redirect and a flush window.
//
// state  | meaning
// IDLE   | accepting events from a non-bubble XB instruction
// ENTER  | trap entry: trap_commit, redirect_valid and flush asserted
// RETURN | MRET: mret_commit, redirect_valid and flush asserted
// SETTLE | flush held while the pipeline drains; all inputs ignored
module trap_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          VECTORED      = 1'b0
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        XB_bubble,
    input  logic [31:0] XB_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_tval,
    input  logic        XB_mret,
    input  logic        irq_ext,
    input  logic        irq_soft,
    input  logic        irq_timer,
    input  logic        csr_mstatus_mie,
    input  logic [2:0]  csr_mie,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        trap_commit,
    output logic [31:0] trap_epc,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_tval,
    output logic        mret_commit,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [2:0]  mip
);

    typedef enum logic [1:0] {IDLE, ENTER, RETURN, SETTLE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ext_s1_q, ext_s2_q, soft_q, timer_q;
    logic        trap_commit_q, trap_commit_d;
    logic        mret_commit_q, mret_commit_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        flush_q, flush_d;
    logic [31:0] trap_epc_q, trap_epc_d;
    logic [31:0] trap_cause_q, trap_cause_d;
    logic [31:0] trap_tval_q, trap_tval_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [2:0]  pending;
    logic [3:0]  irq_code;
    logic [31:0] vec_base;
    logic [31:0] irq_target;

    // Low address bits of the vector base and return address are architecturally ignored.
    logic unused_low_bits;
    assign unused_low_bits = ^{csr_mtvec[1:0], csr_mepc[1:0]};

    assign pending    = {ext_s2_q, soft_q, timer_q} & csr_mie & {3{csr_mstatus_mie}};
    assign irq_code   = pending[2] ? 4'd11 : (pending[1] ? 4'd3 : 4'd7);
    assign vec_base   = {csr_mtvec[31:2], 2'b00};
    assign irq_target = VECTORED ? (vec_base + {26'b0, irq_code, 2'b00}) : vec_base;

    // Next-state and registered-output computation; pulses are decoded from the next state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        trap_epc_d    = trap_epc_q;
        trap_cause_d  = trap_cause_q;
        trap_tval_d   = trap_tval_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (!XB_bubble) begin
                    if (exc_valid) begin
                        state_d       = ENTER;
                        trap_epc_d    = XB_pc;
                        trap_cause_d  = {28'b0, exc_code};
                        trap_tval_d   = exc_tval;
                        redirect_pc_d = vec_base;
                    end else if (|pending) begin
                        // An interrupt also pre-empts an MRET sitting in XB.
                        state_d       = ENTER;
                        trap_epc_d    = XB_pc;
                        trap_cause_d  = {1'b1, 27'b0, irq_code};
                        trap_tval_d   = 32'b0;
                        redirect_pc_d = irq_target;
                    end else if (XB_mret) begin
                        state_d       = RETURN;
                        trap_epc_d    = XB_pc;
                        redirect_pc_d = {csr_mepc[31:2], 2'b00};
                    end
                end
            end
            ENTER, RETURN: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_CYCLES[3:0];
            end
            SETTLE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        trap_commit_d    = (state_d == ENTER);
        mret_commit_d    = (state_d == RETURN);
        redirect_valid_d = (state_d == ENTER) || (state_d == RETURN);
        flush_d          = (state_d != IDLE);
    end

    // State, settle counter, interrupt synchronizers and registered outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            ext_s1_q         <= 1'b0;
            ext_s2_q         <= 1'b0;
            soft_q           <= 1'b0;
            timer_q          <= 1'b0;
            trap_commit_q    <= 1'b0;
            mret_commit_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            trap_epc_q       <= 32'b0;
            trap_cause_q     <= 32'b0;
            trap_tval_q      <= 32'b0;
            redirect_pc_q    <= 32'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ext_s1_q         <= irq_ext;
            ext_s2_q         <= ext_s1_q;
            soft_q           <= irq_soft;
            timer_q          <= irq_timer;
            trap_commit_q    <= trap_commit_d;
            mret_commit_q    <= mret_commit_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            trap_epc_q       <= trap_epc_d;
            trap_cause_q     <= trap_cause_d;
            trap_tval_q      <= trap_tval_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign trap_commit    = trap_commit_q;
    assign mret_commit    = mret_commit_q;
    assign redirect_valid = redirect_valid_q;
    assign flush          = flush_q;
    assign trap_epc       = trap_epc_q;
    assign trap_cause     = trap_cause_q;
    assign trap_tval      = trap_tval_q;
    assign redirect_pc    = redirect_pc_q;
    assign mip            = {ext_s2_q, soft_q, timer_q};

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the trap rules.
module tb_trap_sequencer;

    localparam int unsigned SETTLE = 2;
    localparam bit          VEC    = 1'b1;

    logic        clk, resetb;
    logic        XB_bubble, exc_valid, XB_mret;
    logic [31:0] XB_pc, exc_tval, csr_mtvec, csr_mepc;
    logic [3:0]  exc_code;
    logic        irq_ext, irq_soft, irq_timer, csr_mstatus_mie;
    logic [2:0]  csr_mie;
    logic        trap_commit, mret_commit, redirect_valid, flush;
    logic [31:0] trap_epc, trap_cause, trap_tval, redirect_pc;
    logic [2:0]  mip;

    trap_sequencer #(.SETTLE_CYCLES(SETTLE), .VECTORED(VEC)) dut (
        .clk(clk), .resetb(resetb), .XB_bubble(XB_bubble), .XB_pc(XB_pc),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
        .XB_mret(XB_mret), .irq_ext(irq_ext), .irq_soft(irq_soft),
        .irq_timer(irq_timer), .csr_mstatus_mie(csr_mstatus_mie),
        .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .trap_commit(trap_commit), .trap_epc(trap_epc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_commit(mret_commit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .mip(mip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: cycles of busy time left, the expected output values, and
    // the first stage of the external-interrupt synchronizer.
    int          busy_left;
    logic        e_commit, e_mret, e_redir, e_flush;
    logic [2:0]  e_mip;
    logic [31:0] e_epc, e_cause, e_tval, e_pc;
    logic        m_ext_s1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy_left = 0;
        e_commit = 0; e_mret = 0; e_redir = 0; e_flush = 0;
        e_mip = 3'b000; m_ext_s1 = 0;
        e_epc = 0; e_cause = 0; e_tval = 0; e_pc = 0;
    endtask

    // Predict the values registered at the coming clock edge from the inputs now applied.
    task automatic model_advance();
        logic [2:0]  en;
        int unsigned code;
        logic        took;
        took = 0;
        e_commit = 0; e_mret = 0; e_redir = 0;
        if (busy_left == 0 && !XB_bubble) begin
            en = e_mip & csr_mie & (csr_mstatus_mie ? 3'b111 : 3'b000);
            if (exc_valid) begin
                took = 1; e_commit = 1;
                e_epc = XB_pc; e_cause = 32'(exc_code); e_tval = exc_tval;
                e_pc = csr_mtvec & 32'hFFFF_FFFC;
            end else if (en != 0) begin
                code = en[2] ? 11 : (en[1] ? 3 : 7);
                took = 1; e_commit = 1;
                e_epc = XB_pc; e_cause = 32'h8000_0000 | code; e_tval = 0;
                e_pc = (csr_mtvec & 32'hFFFF_FFFC) + (VEC ? code * 4 : 0);
            end else if (XB_mret) begin
                took = 1; e_mret = 1;
                e_epc = XB_pc;
                e_pc = csr_mepc & 32'hFFFF_FFFC;
            end
        end
        if (took) busy_left = 1 + SETTLE;
        else if (busy_left > 0) busy_left--;
        e_redir = took;
        e_flush = (busy_left > 0);
        e_mip = {m_ext_s1, irq_soft, irq_timer};
        m_ext_s1 = irq_ext;
    endtask

    task automatic compare_all();
        check("trap_commit", 32'(trap_commit), 32'(e_commit));
        check("mret_commit", 32'(mret_commit), 32'(e_mret));
        check("redirect_valid", 32'(redirect_valid), 32'(e_redir));
        check("flush", 32'(flush), 32'(e_flush));
        check("mip", 32'(mip), 32'(e_mip));
        check("trap_epc", trap_epc, e_epc);
        check("trap_cause", trap_cause, e_cause);
        check("trap_tval", trap_tval, e_tval);
        check("redirect_pc", redirect_pc, e_pc);
    endtask

    // One clock: model predicts, DUT registers, then everything is compared.
    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    logic [3:0] codes [6];

    initial begin
        codes[0] = 4'd0; codes[1] = 4'd2; codes[2] = 4'd3;
        codes[3] = 4'd4; codes[4] = 4'd6; codes[5] = 4'd11;
        resetb = 0; XB_bubble = 1; XB_pc = 0; exc_valid = 0; exc_code = 0;
        exc_tval = 0; XB_mret = 0; irq_ext = 0; irq_soft = 0; irq_timer = 0;
        csr_mstatus_mie = 0; csr_mie = 0; csr_mtvec = 0; csr_mepc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        resetb = 1;

        // Exception entry and the flush window that follows it.
        XB_bubble = 0; exc_valid = 1; exc_code = 4'd2; exc_tval = 32'hDEAD_BEEF;
        XB_pc = 32'h100; csr_mtvec = 32'h4;
        step();
        check("exc_commit", 32'(trap_commit), 32'd1);
        check("exc_cause", trap_cause, 32'd2);
        check("exc_epc", trap_epc, 32'h100);
        check("exc_pc", redirect_pc, 32'h4);
        exc_valid = 0; XB_bubble = 1;
        step(); step();
        check("exc_flush_3rd", 32'(flush), 32'd1);
        step();
        check("exc_flush_end", 32'(flush), 32'd0);

        // Interrupt priority: external over timer, then timer alone, vectored targets.
        csr_mstatus_mie = 1; csr_mie = 3'b111; irq_ext = 1; irq_timer = 1;
        step(); step(); step();
        XB_bubble = 0; XB_pc = 32'h300; csr_mtvec = 32'h200;
        step();
        check("irq_ext_cause", trap_cause, 32'h8000_000B);
        check("irq_ext_pc", redirect_pc, 32'h22C);
        XB_bubble = 1; irq_ext = 0;
        repeat (4) step();
        XB_bubble = 0;
        step();
        check("irq_tmr_cause", trap_cause, 32'h8000_0007);
        check("irq_tmr_pc", redirect_pc, 32'h21C);
        XB_bubble = 1; irq_timer = 0;
        repeat (4) step();

        // Exception beats a pending timer and an MRET; timer follows after settle.
        irq_timer = 1;
        step();
        XB_bubble = 0; exc_valid = 1; exc_code = 4'd11; XB_mret = 1; XB_pc = 32'h440;
        step();
        check("exc_win_cause", trap_cause, 32'd11);
        check("exc_win_nomret", 32'(mret_commit), 32'd0);
        exc_valid = 0; XB_mret = 0;
        repeat (4) step();
        check("late_tmr_commit", 32'(trap_commit), 32'd1);
        check("late_tmr_cause", trap_cause, 32'h8000_0007);
        XB_bubble = 1; irq_timer = 0;
        repeat (4) step();

        // MRET, then MRET with interrupts globally disabled and timer pending.
        XB_bubble = 0; XB_mret = 1; csr_mepc = 32'h1F0;
        step();
        check("mret_commit", 32'(mret_commit), 32'd1);
        check("mret_pc", redirect_pc, 32'h1F0);
        check("mret_notrap", 32'(trap_commit), 32'd0);
        XB_bubble = 1; XB_mret = 0;
        repeat (3) step();
        csr_mstatus_mie = 0; irq_timer = 1;
        step();
        XB_bubble = 0; XB_mret = 1;
        step();
        check("mret_mie0", 32'(mret_commit), 32'd1);
        XB_bubble = 1; XB_mret = 0;
        repeat (3) step();

        // Bubble gating, then an exception pulse during SETTLE is ignored.
        csr_mstatus_mie = 1;
        repeat (3) begin
            step();
            check("bubble_nocommit", 32'(trap_commit), 32'd0);
        end
        XB_bubble = 0;
        step();
        check("post_bubble_commit", 32'(trap_commit), 32'd1);
        irq_timer = 0; exc_valid = 1;
        repeat (2) begin
            step();
            check("settle_noexc", 32'(trap_commit), 32'd0);
        end
        exc_valid = 0; XB_bubble = 1;
        repeat (3) step();

        // Asynchronous reset in the first SETTLE cycle.
        irq_soft = 1;
        step();
        XB_bubble = 0; exc_valid = 1; exc_code = 4'd6;
        step();
        exc_valid = 0; XB_bubble = 1;
        step();
        check("pre_rst_flush", 32'(flush), 32'd1);
        irq_soft = 0;
        #2 resetb = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 resetb = 1;
        repeat (4) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            XB_bubble       = ($urandom_range(0, 9) < 3);
            exc_valid       = ($urandom_range(0, 9) < 2);
            exc_code        = codes[$urandom_range(0, 5)];
            exc_tval        = $urandom;
            XB_mret         = ($urandom_range(0, 9) < 2);
            XB_pc           = $urandom;
            csr_mepc        = $urandom;
            csr_mtvec       = $urandom;
            csr_mstatus_mie = ($urandom_range(0, 3) != 0);
            csr_mie         = 3'($urandom);
            if ($urandom_range(0, 7) == 0) irq_ext   = ~irq_ext;
            if ($urandom_range(0, 7) == 0) irq_soft  = ~irq_soft;
            if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences every control transfer into and out of machine-mode traps for the pipelined core.
- Arbitrates between three request classes: synchronous exceptions flagged by the CSR/exception unit in XB, level-sensitive machine interrupts (external, software, timer), and MRET committing in XB.
- For the winner it issues a one-cycle commit pulse to the CSR file (mepc/mcause/mtval/mstatus update), a PC redirect, and a pipeline flush window.
- Sits between the CSR/exception unit, the fetch PC mux and the pipeline stall/flush logic.

Parameters:
- SETTLE_CYCLES, 2, cycles flush stays asserted after a redirect before new events are accepted (1..15).
- VECTORED, 0, 1 = interrupts redirect to mtvec_base + 4*code; exceptions always go to mtvec_base.

Ports:
- clk  in  1  core clock
- resetb  in  1  asynchronous active-low reset
- XB_bubble  in  1  XB stage holds no instruction
- XB_pc  in  32  PC of the XB instruction
- exc_valid  in  1  exception pending for the XB instruction (initiate_exception)
- exc_code  in  4  exception cause code (0,2,3,4,6,11)
- exc_tval  in  32  trap value for the exception
- XB_mret  in  1  XB instruction is MRET
- irq_ext  in  1  external interrupt, asynchronous level
- irq_soft  in  1  software interrupt, synchronous level
- irq_timer  in  1  timer interrupt, synchronous level
- csr_mstatus_mie  in  1  global interrupt enable
- csr_mie  in  3  {MEIE, MSIE, MTIE}
- csr_mtvec  in  32  trap vector base; bits [1:0] ignored
- csr_mepc  in  32  return address
- trap_commit  out  1  one-cycle pulse: CSR writes mepc/mcause/mtval and sets mpie<=mie, mie<=0
- trap_epc  out  32  value for mepc
- trap_cause  out  32  value for mcause; bit 31 = interrupt
- trap_tval  out  32  value for mtval
- mret_commit  out  1  one-cycle pulse: CSR sets mie<=mpie, mpie<=1
- redirect_valid  out  1  one-cycle pulse: fetch loads redirect_pc
- redirect_pc  out  32  target PC
- flush  out  1  squash FD and XB contents
- mip  out  3  {MEIP, MSIP, MTIP} pending view, for CSR reads

Behaviour:
- Reset values: all pulses 0, flush 0, mip 0, trap_epc/trap_cause/trap_tval/redirect_pc 0, state IDLE, settle counter 0.
- Reset is asynchronous; asserting it mid-SETTLE returns to IDLE immediately, with no pulse or redirect.
- irq_ext passes through a 2-flop synchronizer. irq_soft and irq_timer are registered once.
- mip = {ext_sync, soft_q, timer_q}, updated every cycle regardless of state.
- States: IDLE, ENTER, RETURN, SETTLE.
- An event is evaluated only in IDLE with XB_bubble = 0.
- Priority, highest first:
  1. exc_valid.
  2. Enabled interrupt: csr_mstatus_mie & (mip & csr_mie) != 0. Among interrupts, ext (code 11) > soft (3) > timer (7).
  3. XB_mret.
- An interrupt coincident with MRET wins; the MRET is not executed and its PC becomes mepc.
- Evaluation cycle T (IDLE, event, non-bubble), registered at the edge ending T:
  - trap_epc <= XB_pc.
  - Exception: trap_cause <= {28'b0, exc_code}, trap_tval <= exc_tval, redirect_pc <= {csr_mtvec[31:2], 2'b00}.
  - Interrupt: trap_cause <= {1'b1, 27'b0, code}, trap_tval <= 0, redirect_pc <= base + (VECTORED ? code<<2 : 0).
  - MRET: redirect_pc <= {csr_mepc[31:2], 2'b00}.
  - State moves to ENTER (trap) or RETURN (MRET).
- ENTER (cycle T+1): trap_commit = 1, redirect_valid = 1, flush = 1. Next state SETTLE with counter = SETTLE_CYCLES.
- RETURN (cycle T+1): mret_commit = 1, redirect_valid = 1, flush = 1. Next state SETTLE.
- SETTLE: flush = 1. Counter decrements each cycle; on reaching 0 (SETTLE_CYCLES cycles) the state goes to IDLE. All inputs are ignored, and interrupts remain pending in mip.
- Total redirect latency is 1 cycle from evaluation. The block is busy for 1 + SETTLE_CYCLES cycles.
- Bubble in XB while IDLE: no action, even with an interrupt pending. The interrupt is taken on the next non-bubble XB.
- The interrupt enable check uses the csr_* values sampled in cycle T. A CSR write landing in the same cycle takes effect on the next evaluation.
- VECTORED address arithmetic is modulo 2^32.

Test Plan:
- Reset mid-SETTLE: set SETTLE_CYCLES=2, take a trap, assert resetb=0 in the first SETTLE cycle -> flush=0 and mip=0 asynchronously, state IDLE, no further pulses after release.
- Exception: exc_valid=1, exc_code=2, XB_pc=0x100, csr_mtvec=0x4 -> next cycle trap_commit=1, trap_cause=2, trap_epc=0x100, redirect_pc=0x4. flush high for 3 cycles total, then IDLE.
- Interrupt priority: csr_mstatus_mie=1, csr_mie=3'b111, irq_ext held high 3 cycles, irq_timer=1 -> trap_cause=0x8000000B. With ext low -> 0x80000007. With VECTORED=1 and mtvec=0x200 -> redirect_pc=0x22C.
- Exception beats interrupt and MRET: exc_valid=1, code 11, pending enabled timer and XB_mret=1 -> cause=11, no mret_commit. Timer is taken at the first non-bubble after SETTLE.
- MRET: XB_mret=1, csr_mepc=0x1F0 -> mret_commit=1, redirect_pc=0x1F0, trap_commit=0. Same with mstatus_mie=0 and irq_timer=1 -> still MRET.
- Bubble/settle gating: interrupt pending while XB_bubble=1 -> no commit. An exc_valid pulse during SETTLE -> ignored, no second trap_commit.
